// File: rtl/rope_grab_detector.sv
// Collects player/rope sprite overlap per frame; at each frame boundary runs the grab/hold/release FSM.
// All outputs are registered, so a frame decision appears the cycle after startOfFrame.
module rope_grab_detector #(
  parameter int GRAB_FRAMES     = 3,
  parameter int RELEASE_FRAMES  = 2,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic [10:0]        pixelX,
  input  logic [10:0]        pixelY,
  input  logic               playerDrawingRequest,
  input  logic               ropeDrawingRequest,
  input  logic signed [10:0] ropeTopLeftY,
  input  logic               releaseKey,
  output logic               frameHit,
  output logic               grabbed,
  output logic               grabPulse,
  output logic               releasePulse,
  output logic [10:0]        grabOffsetY,
  output logic [10:0]        contactX
);

  typedef enum logic [1:0] {
    ST_FREE     = 2'd0,
    ST_GRABBED  = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_t;

  localparam logic [10:0] MIN_OFF_INIT = 11'd2047;
  localparam logic [4:0]  GRAB_LIM     = 5'(GRAB_FRAMES);
  localparam logic [4:0]  REL_LIM      = 5'(RELEASE_FRAMES);
  localparam logic [8:0]  COOL_LIM     = 9'(COOLDOWN_FRAMES);

  state_t      state_q, state_d;
  logic [3:0]  hit_cnt_q, hit_cnt_d;
  logic [3:0]  miss_cnt_q, miss_cnt_d;
  logic [7:0]  cool_cnt_q, cool_cnt_d;

  logic        hit_acc_q, hit_acc_d;
  logic [10:0] min_off_q, min_off_d;
  logic [10:0] first_x_q, first_x_d;
  logic        first_cap_q, first_cap_d;
  logic        rel_latch_q, rel_latch_d;

  logic        frame_hit_q, frame_hit_d;
  logic        grabbed_q, grabbed_d;
  logic        grab_pulse_q, grab_pulse_d;
  logic        release_pulse_q, release_pulse_d;
  logic [10:0] grab_offset_y_q, grab_offset_y_d;
  logic [10:0] contact_x_q, contact_x_d;

  logic               overlap;
  logic signed [12:0] diff_raw;
  logic [10:0]        diff_clamped;
  logic [10:0]        off_min;
  logic [10:0]        first_x_now;
  logic               frame_h;
  logic               frame_rel;
  logic [4:0]         hit_cnt_inc;
  logic [4:0]         miss_cnt_inc;
  logic [8:0]         cool_cnt_inc;

  // Offset is widened to 13 bits so the full pixelY/ropeTopLeftY range cannot wrap before clamping.
  always_comb begin
    overlap      = playerDrawingRequest & ropeDrawingRequest;
    diff_raw     = $signed({2'b00, pixelY}) - $signed({{2{ropeTopLeftY[10]}}, ropeTopLeftY});
    if (diff_raw < 13'sd0) begin
      diff_clamped = 11'd0;
    end else if (diff_raw > 13'sd2047) begin
      diff_clamped = 11'd2047;
    end else begin
      diff_clamped = diff_raw[10:0];
    end
    off_min      = (overlap && (diff_clamped < min_off_q)) ? diff_clamped : min_off_q;
    first_x_now  = first_cap_q ? first_x_q : pixelX;
    frame_h      = hit_acc_q | overlap;
    frame_rel    = rel_latch_q | releaseKey;
    hit_cnt_inc  = {1'b0, hit_cnt_q} + 5'd1;
    miss_cnt_inc = {1'b0, miss_cnt_q} + 5'd1;
    cool_cnt_inc = {1'b0, cool_cnt_q} + 9'd1;
  end

  always_comb begin
    state_d         = state_q;
    hit_cnt_d       = hit_cnt_q;
    miss_cnt_d      = miss_cnt_q;
    cool_cnt_d      = cool_cnt_q;
    hit_acc_d       = hit_acc_q;
    min_off_d       = min_off_q;
    first_x_d       = first_x_q;
    first_cap_d     = first_cap_q;
    rel_latch_d     = rel_latch_q;
    frame_hit_d     = frame_hit_q;
    grab_pulse_d    = 1'b0;
    release_pulse_d = 1'b0;
    grab_offset_y_d = grab_offset_y_q;
    contact_x_d     = contact_x_q;

    if (startOfFrame) begin
      // The sample cycle itself belongs to the closing frame.
      frame_hit_d = frame_h;
      if (frame_h) begin
        contact_x_d = first_x_now;
      end
      hit_acc_d   = 1'b0;
      min_off_d   = MIN_OFF_INIT;
      first_cap_d = 1'b0;
      first_x_d   = 11'd0;
      rel_latch_d = 1'b0;

      unique case (state_q)
        ST_FREE: begin
          if (frame_h) begin
            if (hit_cnt_inc == GRAB_LIM) begin
              state_d         = ST_GRABBED;
              grab_pulse_d    = 1'b1;
              grab_offset_y_d = off_min;
              hit_cnt_d       = 4'd0;
              miss_cnt_d      = 4'd0;
            end else if (hit_cnt_q != 4'hF) begin
              hit_cnt_d = hit_cnt_inc[3:0];
            end
          end else begin
            hit_cnt_d = 4'd0;
          end
        end
        ST_GRABBED: begin
          if (frame_rel) begin
            state_d         = ST_COOLDOWN;
            release_pulse_d = 1'b1;
            cool_cnt_d      = 8'd0;
            miss_cnt_d      = 4'd0;
            hit_cnt_d       = 4'd0;
          end else if (frame_h) begin
            miss_cnt_d      = 4'd0;
            grab_offset_y_d = off_min;
          end else if (miss_cnt_inc == REL_LIM) begin
            state_d         = ST_FREE;
            release_pulse_d = 1'b1;
            miss_cnt_d      = 4'd0;
            hit_cnt_d       = 4'd0;
          end else begin
            miss_cnt_d = miss_cnt_inc[3:0];
          end
        end
        ST_COOLDOWN: begin
          hit_cnt_d = 4'd0;
          if (cool_cnt_inc == COOL_LIM) begin
            state_d    = ST_FREE;
            cool_cnt_d = 8'd0;
          end else begin
            cool_cnt_d = cool_cnt_inc[7:0];
          end
        end
        default: begin
          state_d = ST_FREE;
        end
      endcase
    end else begin
      if (overlap) begin
        hit_acc_d = 1'b1;
        min_off_d = off_min;
        if (!first_cap_q) begin
          first_cap_d = 1'b1;
          first_x_d   = pixelX;
        end
      end
      if (releaseKey) begin
        rel_latch_d = 1'b1;
      end
    end

    grabbed_d = (state_d == ST_GRABBED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_FREE;
      hit_cnt_q       <= 4'd0;
      miss_cnt_q      <= 4'd0;
      cool_cnt_q      <= 8'd0;
      hit_acc_q       <= 1'b0;
      min_off_q       <= MIN_OFF_INIT;
      first_x_q       <= 11'd0;
      first_cap_q     <= 1'b0;
      rel_latch_q     <= 1'b0;
      frame_hit_q     <= 1'b0;
      grabbed_q       <= 1'b0;
      grab_pulse_q    <= 1'b0;
      release_pulse_q <= 1'b0;
      grab_offset_y_q <= 11'd0;
      contact_x_q     <= 11'd0;
    end else begin
      state_q         <= state_d;
      hit_cnt_q       <= hit_cnt_d;
      miss_cnt_q      <= miss_cnt_d;
      cool_cnt_q      <= cool_cnt_d;
      hit_acc_q       <= hit_acc_d;
      min_off_q       <= min_off_d;
      first_x_q       <= first_x_d;
      first_cap_q     <= first_cap_d;
      rel_latch_q     <= rel_latch_d;
      frame_hit_q     <= frame_hit_d;
      grabbed_q       <= grabbed_d;
      grab_pulse_q    <= grab_pulse_d;
      release_pulse_q <= release_pulse_d;
      grab_offset_y_q <= grab_offset_y_d;
      contact_x_q     <= contact_x_d;
    end
  end

  assign frameHit     = frame_hit_q;
  assign grabbed      = grabbed_q;
  assign grabPulse    = grab_pulse_q;
  assign releasePulse = release_pulse_q;
  assign grabOffsetY  = grab_offset_y_q;
  assign contactX     = contact_x_q;

endmodule

// File: tb/tb_rope_grab_detector.sv
// Bench for rope_grab_detector: directed scenarios plus random frames against a frame-level model.
module tb_rope_grab_detector;

  localparam int GRAB_N = 3;
  localparam int REL_N  = 2;
  localparam int COOL_N = 8;

  logic               clk;
  logic               reset;
  logic               startOfFrame;
  logic [10:0]        pixelX;
  logic [10:0]        pixelY;
  logic               playerDrawingRequest;
  logic               ropeDrawingRequest;
  logic signed [10:0] ropeTopLeftY;
  logic               releaseKey;
  logic               frameHit;
  logic               grabbed;
  logic               grabPulse;
  logic               releasePulse;
  logic [10:0]        grabOffsetY;
  logic [10:0]        contactX;

  rope_grab_detector #(
    .GRAB_FRAMES(GRAB_N), .RELEASE_FRAMES(REL_N), .COOLDOWN_FRAMES(COOL_N)
  ) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
    .pixelX(pixelX), .pixelY(pixelY),
    .playerDrawingRequest(playerDrawingRequest), .ropeDrawingRequest(ropeDrawingRequest),
    .ropeTopLeftY(ropeTopLeftY), .releaseKey(releaseKey),
    .frameHit(frameHit), .grabbed(grabbed), .grabPulse(grabPulse),
    .releasePulse(releasePulse), .grabOffsetY(grabOffsetY), .contactX(contactX)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: mode 0 free, 1 holding rope, 2 cooling down after a key release.
  int mode       = 0;
  int hit_run    = 0;
  int miss_run   = 0;
  int cool_done  = 0;
  bit f_hit      = 0;
  int f_min      = 2047;
  int f_first    = -1;
  bit f_rel      = 0;
  int e_frame_hit = 0;
  int e_grabbed   = 0;
  int e_gp        = 0;
  int e_rp        = 0;
  int e_off       = 0;
  int e_cx        = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_step(input bit sof, input bit ovl, input int px, input int py,
                            input int ry, input bit key, input bit rst);
    int d;
    int fmin;
    int fx;
    bit h;
    bit rel;
    if (rst) begin
      mode = 0; hit_run = 0; miss_run = 0; cool_done = 0;
      f_hit = 0; f_min = 2047; f_first = -1; f_rel = 0;
      e_frame_hit = 0; e_grabbed = 0; e_gp = 0; e_rp = 0; e_off = 0; e_cx = 0;
      return;
    end
    d = py - ry;
    if (d < 0) d = 0;
    if (d > 2047) d = 2047;
    e_gp = 0;
    e_rp = 0;
    if (!sof) begin
      if (ovl) begin
        f_hit = 1;
        if (d < f_min) f_min = d;
        if (f_first < 0) f_first = px;
      end
      if (key) f_rel = 1;
    end else begin
      h    = f_hit || ovl;
      fmin = (ovl && d < f_min) ? d : f_min;
      fx   = (f_first >= 0) ? f_first : px;
      rel  = f_rel || key;
      e_frame_hit = h;
      if (h) e_cx = fx;
      if (mode == 0) begin
        if (h) begin
          hit_run++;
          if (hit_run >= GRAB_N) begin
            mode = 1; e_gp = 1; e_off = fmin; hit_run = 0; miss_run = 0;
          end
        end else hit_run = 0;
      end else if (mode == 1) begin
        if (rel) begin
          mode = 2; e_rp = 1; cool_done = 0;
        end else if (h) begin
          miss_run = 0; e_off = fmin;
        end else begin
          miss_run++;
          if (miss_run >= REL_N) begin
            mode = 0; e_rp = 1; miss_run = 0; hit_run = 0;
          end
        end
      end else begin
        cool_done++;
        if (cool_done >= COOL_N) begin
          mode = 0; hit_run = 0;
        end
      end
      f_hit = 0; f_min = 2047; f_first = -1; f_rel = 0;
    end
    e_grabbed = (mode == 1);
  endtask

  task automatic tick(input bit sof, input bit pd, input bit rd, input int px, input int py,
                      input int ry, input bit key, input bit rst);
    logic signed [10:0] ry_s;
    ry_s = 11'(ry);
    startOfFrame = sof; playerDrawingRequest = pd; ropeDrawingRequest = rd;
    pixelX = 11'(px); pixelY = 11'(py); ropeTopLeftY = ry_s; releaseKey = key; reset = rst;
    @(posedge clk);
    model_step(sof, pd && rd, px & 2047, py & 2047, int'(ry_s), key, rst);
    #1;
    chk("frameHit", {31'd0, frameHit}, e_frame_hit);
    chk("grabbed", {31'd0, grabbed}, e_grabbed);
    chk("grabPulse", {31'd0, grabPulse}, e_gp);
    chk("releasePulse", {31'd0, releasePulse}, e_rp);
    chk("grabOffsetY", {21'd0, grabOffsetY}, e_off);
    chk("contactX", {21'd0, contactX}, e_cx);
  endtask

  // hm: 0 no overlap, 1 overlap mid-frame, 2 overlap only on the startOfFrame cycle.
  task automatic frame(input int hm, input int px, input int py, input int ry, input bit key);
    for (int i = 0; i < 6; i++)
      tick(0, 1'b1, (hm == 1) && (i == 2), px + i, py, ry, key && (i == 3), 0);
    tick(1, hm == 2, hm == 2, px, py, ry, 0, 0);
  endtask

  initial begin
    startOfFrame = 0; playerDrawingRequest = 0; ropeDrawingRequest = 0;
    pixelX = 0; pixelY = 0; ropeTopLeftY = 0; releaseKey = 0; reset = 1;
    tick(0, 0, 0, 0, 0, 0, 0, 1);

    // Reset mid-frame with overlap discards the partial frame.
    tick(0, 1, 1, 40, 150, 100, 0, 0);
    tick(0, 1, 1, 41, 150, 100, 0, 0);
    tick(0, 1, 1, 42, 150, 100, 0, 1);
    chk("t1_frameHit_rst", {31'd0, frameHit}, 0);
    chk("t1_grabbed_rst", {31'd0, grabbed}, 0);
    chk("t1_contactX_rst", {21'd0, contactX}, 0);
    frame(0, 10, 150, 100, 0);
    chk("t1_frameHit_after", {31'd0, frameHit}, 0);

    // Three hit frames grab with offset 150-100.
    frame(1, 200, 150, 100, 0);
    frame(1, 200, 150, 100, 0);
    chk("t2_no_grab_yet", {31'd0, grabbed}, 0);
    frame(1, 200, 150, 100, 0);
    chk("t2_grabPulse", {31'd0, grabPulse}, 1);
    chk("t2_grabbed", {31'd0, grabbed}, 1);
    chk("t2_offset", {21'd0, grabOffsetY}, 50);
    tick(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t2_pulse_one_cycle", {31'd0, grabPulse}, 0);

    // Single miss is tolerated, two misses slip off.
    frame(0, 200, 150, 100, 0);
    frame(1, 200, 150, 100, 0);
    chk("t5_still_grabbed", {31'd0, grabbed}, 1);
    frame(0, 200, 150, 100, 0);
    frame(0, 200, 150, 100, 0);
    chk("t5_releasePulse", {31'd0, releasePulse}, 1);
    chk("t5_free", {31'd0, grabbed}, 0);

    // A miss in the middle restarts the hit count.
    frame(1, 300, 160, 100, 0);
    frame(1, 300, 160, 100, 0);
    frame(0, 300, 160, 100, 0);
    frame(1, 300, 160, 100, 0);
    frame(1, 300, 160, 100, 0);
    chk("t3_no_grab_5", {31'd0, grabbed}, 0);
    frame(1, 300, 170, 100, 0);
    chk("t3_grab_6", {31'd0, grabPulse}, 1);
    chk("t3_offset", {21'd0, grabOffsetY}, 70);

    // Key release while overlapping, then cooldown ignores hits.
    frame(1, 300, 170, 100, 1);
    chk("t4_releasePulse", {31'd0, releasePulse}, 1);
    chk("t4_grabbed0", {31'd0, grabbed}, 0);
    for (int f = 0; f < COOL_N; f++) frame(1, 300, 170, 100, 0);
    chk("t4_cooldown_no_grab", {31'd0, grabbed}, 0);
    frame(1, 300, 170, 100, 0);
    frame(1, 300, 170, 100, 0);
    chk("t4_two_after_cool", {31'd0, grabbed}, 0);
    frame(1, 300, 170, 100, 0);
    chk("t4_grab_after_cool", {31'd0, grabPulse}, 1);

    // Overlap only on the sample cycle, above the rope top (clamped to 0).
    tick(0, 0, 0, 0, 0, 0, 0, 1);
    frame(2, 300, 90, 100, 0);
    chk("t6_frameHit", {31'd0, frameHit}, 1);
    chk("t6_contactX", {21'd0, contactX}, 300);
    frame(2, 300, 90, 100, 0);
    frame(2, 300, 90, 100, 0);
    chk("t6_grabbed", {31'd0, grabbed}, 1);
    chk("t6_offset_clamped", {21'd0, grabOffsetY}, 0);

    // Random frames checked cycle by cycle against the model.
    for (int f = 0; f < 400; f++) begin
      int len;
      int hit_pct;
      int ry;
      int ybase;
      len     = $urandom_range(2, 10);
      hit_pct = ($urandom_range(0, 99) < 70) ? 40 : 0;
      ry      = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2047) : $urandom_range(0, 400);
      ybase   = $urandom_range(0, 2047);
      for (int c = 0; c < len; c++) begin
        bit pd;
        bit rd;
        pd = ($urandom_range(0, 99) < 60);
        rd = ($urandom_range(0, 99) < hit_pct);
        tick(0, pd, rd, $urandom_range(0, 2047), ybase + $urandom_range(0, 60) - 30, ry,
             $urandom_range(0, 99) < 3, $urandom_range(0, 999) < 3);
      end
      tick(1, $urandom_range(0, 1) == 1, $urandom_range(0, 99) < hit_pct,
           $urandom_range(0, 2047), ybase, ry, $urandom_range(0, 99) < 3, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
